ro_pair_counter: RTL and testbench
==================================

RO_PAIR_COUNTER -- requirements
Module: ro_pair_counter

Interface
REQ-001 Parameter CNT_W, default 16, width of each edge counter.
REQ-002 Parameter WINDOW, default 1024, measurement window length in Clk cycles (≥4).
REQ-003 Parameter SETTLE, default 4, Clk cycles the ROs are held in reset before counting (≥1).
REQ-004 Clk  input  1  single clock; all state on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  request one measurement; sampled only in IDLE.
REQ-007 Ro_a, Ro_b  input  1 each  ring-oscillator outputs, asynchronous to Clk, frequency ≤ Clk/4.
REQ-008 Ro_en  output  1  enable to both ROs (drives their enable inputs).
REQ-009 Ro_rst  output  1  active-high hold to both ROs (drives their Reset inputs).
REQ-010 Busy  output  1  high from the cycle after Start is accepted until Done.
REQ-011 Done  output  1  one-cycle pulse; results valid from this cycle.
REQ-012 Resp_bit, Tie, Sat  output  1 each  response bit, equal-count flag, saturation flag.
REQ-013 Cnt_a, Cnt_b  output  CNT_W each  final edge counts.

Function
REQ-014 FSM states IDLE, SETTLE, RUN, DRAIN, COMPARE, DONE; encoding free.
REQ-015 IDLE: Ro_rst=1, Ro_en=0; Start=1 -> SETTLE, clears Cnt_a, Cnt_b, Resp_bit, Tie, Sat.
REQ-016 SETTLE: Ro_rst=1, Ro_en=0 for exactly SETTLE cycles -> RUN.
REQ-017 RUN: Ro_rst=0, Ro_en=1 for exactly WINDOW cycles; counters increment on each synchronized rising edge of their RO -> DRAIN.
REQ-018 DRAIN: Ro_en=0, Ro_rst=0, exactly 3 cycles, counters still accept in-flight synchronized edges -> COMPARE.
REQ-019 COMPARE (1 cycle): Resp_bit=(Cnt_a>Cnt_b), Tie=(Cnt_a==Cnt_b) -> DONE.
REQ-020 DONE (1 cycle): Done=1, Ro_rst=1 -> IDLE.
REQ-021 Latency: Done asserted exactly SETTLE+WINDOW+5 cycles after the Start-accept edge (1033 at defaults).
REQ-022 Each RO input passes a 2-flop synchronizer plus a third flop for rising-edge detect.
REQ-023 Counters saturate at 2^CNT_W-1; any saturation sets Sat, sticky until next accepted Start.
REQ-024 Tie=1 forces Resp_bit=0.
REQ-025 Start outside IDLE is ignored, no queuing.
REQ-026 Resp_bit, Tie, Sat, Cnt_a, Cnt_b hold their values from DONE until the next accepted Start.
REQ-027 Edges arriving in SETTLE, IDLE, COMPARE or DONE are not counted.

Reset
REQ-028 Reset_n low, asynchronously: state IDLE, Ro_rst=1, Ro_en=0, Busy=0, Done=0, Resp_bit=0, Tie=0, Sat=0, Cnt_a=0, Cnt_b=0, synchronizer flops 0, window counter 0.
REQ-029 Reset during any state aborts the measurement; no Done is produced; first Start after release behaves per REQ-021.

Structure
REQ-030 Shared package holds the FSM state type and default constants for CNT_W, WINDOW, SETTLE.
REQ-031 One sub-module, ro_edge_counter (synchronizer, edge detect, saturating counter, clear/enable inputs), instantiated twice.
REQ-032 Window counter and FSM live in the top module; window counter width is clog2(WINDOW+1).

Verification
REQ-033 Ro_a=Clk/8, Ro_b=Clk/10, defaults, Start -> Done at cycle 1033, Cnt_a=128±1, Cnt_b=102±1, Resp_bit=1, Tie=0, Sat=0.
REQ-034 Ro_a=Clk/10, Ro_b=Clk/8 -> Resp_bit=0, Tie=0; Ro_a=Ro_b=Clk/8 phase-aligned -> Cnt_a==Cnt_b, Tie=1, Resp_bit=0.
REQ-035 CNT_W=6, Ro_a=Clk/4 -> Cnt_a=63, Sat=1; next Start clears Sat before counting.
REQ-036 Reset_n low for 2 cycles mid-RUN -> all outputs at REQ-028 values immediately, no Done; subsequent Start completes normally.
REQ-037 Start pulsed every cycle during Busy -> exactly one Done per accepted Start, Busy never drops early.
REQ-038 Ro toggling in SETTLE/IDLE only, none in RUN -> Cnt_a=Cnt_b=0, Tie=1.

Source files
------------

// File: rtl/ro_pair_counter_pkg.sv
// ro_pair_counter_pkg
// Shared definitions for the ring-oscillator pair counter:
//   - default parameter values for counter width, window and settle length
//   - drain length (covers the 2-flop synchronizer plus edge-detect flop)
//   - FSM state type used by the top module
package ro_pair_counter_pkg;

    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_WINDOW   = 1024;
    localparam int unsigned DEF_SETTLE   = 4;
    localparam int unsigned DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StRun,
        StDrain,
        StCompare,
        StDone
    } state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter
// Counts rising edges of one asynchronous ring-oscillator output.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ro           : raw RO output (asynchronous to i_clk)
//   i_flush        : hold the synchronizer/edge-detect flops at 0
//   i_clr          : clear count and saturation flag
//   i_en           : accept detected edges into the counter
//   o_cnt          : saturating edge count
//   o_sat          : sticky, set once the count reaches its maximum
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ro,
    input  logic             i_flush,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_rise;
    logic             w_at_max;
    logic [CNT_W-1:0] w_cnt_inc;

    // Two flops of synchronization, third flop remembers the previous level.
    // Flushing keeps edges seen while the RO is held from leaking into RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else if (i_flush) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_ro;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_at_max  = &r_cnt;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_en && w_rise) begin
            if (w_at_max) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= w_cnt_inc;
                // Reaching all-ones means further edges can no longer be told apart.
                r_sat <= r_sat | (&w_cnt_inc);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/ro_pair_counter.sv
// ro_pair_counter
// Measures two ring oscillators over a fixed window and reports which one
// produced more rising edges (one PUF response bit).
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_start                : request a measurement (sampled in IDLE only)
//   i_ro_a, i_ro_b         : raw RO outputs
//   o_ro_en, o_ro_rst      : RO enable / active-high RO hold
//   o_busy                 : measurement in progress
//   o_done                 : one-cycle pulse, results valid from this cycle
//   o_resp_bit, o_tie      : cnt_a > cnt_b, cnt_a == cnt_b
//   o_sat                  : either counter saturated during the measurement
//   o_cnt_a, o_cnt_b       : final edge counts
// Done appears SETTLE+WINDOW+5 cycles after the Start-accept edge: it is
// registered on the edge that leaves DONE, so it shows in the first IDLE cycle.
module ro_pair_counter
    import ro_pair_counter_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_ro_a,
    input  logic             i_ro_b,
    output logic             o_ro_en,
    output logic             o_ro_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_resp_bit,
    output logic             o_tie,
    output logic             o_sat,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b
);

    localparam int unsigned WCW = $clog2(WINDOW + 1);
    localparam logic [WCW-1:0] SETTLE_LAST = WCW'(SETTLE - 1);
    localparam logic [WCW-1:0] WINDOW_LAST = WCW'(WINDOW - 1);
    localparam logic [WCW-1:0] DRAIN_LAST  = WCW'(DRAIN_CYCLES - 1);

    state_e           r_state;
    logic [WCW-1:0]   r_wcnt;
    logic             r_ro_en;
    logic             r_ro_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_resp;
    logic             r_tie;

    logic             w_accept;
    logic             w_count_en;
    logic             w_flush;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;
    logic             w_sat_a;
    logic             w_sat_b;

    assign w_accept   = (r_state == StIdle) && i_start;
    // DRAIN keeps counting so edges still in the synchronizer are not lost.
    assign w_count_en = (r_state == StRun) || (r_state == StDrain);
    assign w_flush    = !w_count_en;

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (i_ro_a),
        .i_flush (w_flush),
        .i_clr   (w_accept),
        .i_en    (w_count_en),
        .o_cnt   (w_cnt_a),
        .o_sat   (w_sat_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (i_ro_b),
        .i_flush (w_flush),
        .i_clr   (w_accept),
        .i_en    (w_count_en),
        .o_cnt   (w_cnt_b),
        .o_sat   (w_sat_b)
    );

    // r_wcnt times SETTLE, RUN and DRAIN; it restarts from 0 on every state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_wcnt   <= '0;
            r_ro_en  <= 1'b0;
            r_ro_rst <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_resp   <= 1'b0;
            r_tie    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StSettle;
                        r_wcnt  <= '0;
                        r_busy  <= 1'b1;
                        r_resp  <= 1'b0;
                        r_tie   <= 1'b0;
                    end
                end
                StSettle: begin
                    if (r_wcnt == SETTLE_LAST) begin
                        r_state  <= StRun;
                        r_wcnt   <= '0;
                        r_ro_rst <= 1'b0;
                        r_ro_en  <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                StRun: begin
                    if (r_wcnt == WINDOW_LAST) begin
                        r_state <= StDrain;
                        r_wcnt  <= '0;
                        r_ro_en <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                StDrain: begin
                    if (r_wcnt == DRAIN_LAST) begin
                        r_state <= StCompare;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                StCompare: begin
                    // Strict compare: an equal count yields resp 0 with tie 1.
                    r_resp   <= (w_cnt_a > w_cnt_b);
                    r_tie    <= (w_cnt_a == w_cnt_b);
                    r_ro_rst <= 1'b1;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ro_en    = r_ro_en;
    assign o_ro_rst   = r_ro_rst;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_resp_bit = r_resp;
    assign o_tie      = r_tie;
    assign o_sat      = w_sat_a | w_sat_b;
    assign o_cnt_a    = w_cnt_a;
    assign o_cnt_b    = w_cnt_b;

endmodule

// File: tb/tb_ro_pair_counter.sv
module tb_ro_pair_counter;

    localparam int LAT   = 4 + 1024 + 5;
    localparam int S_WIN = 300;
    localparam int S_LAT = 4 + S_WIN + 5;

    typedef struct {
        bit resp;
        bit tie;
        bit sat;
        int a_lo;
        int a_hi;
        int b_lo;
        int b_hi;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ro_a = 1'b0;
    logic        ro_b = 1'b0;
    logic        ro_en, ro_rst, busy, done, resp, tie, sat;
    logic [15:0] cnt_a, cnt_b;

    logic        s_start = 1'b0;
    logic        s_ro = 1'b0;
    logic        s_ro_b = 1'b0;
    logic        s_ro_en, s_ro_rst, s_busy, s_done, s_resp, s_tie, s_sat;
    logic [5:0]  s_cnt_a, s_cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int half_a = 0;
    int half_b = 0;
    int s_half = 0;
    bit noise = 0;
    int ph_a = 0;
    int ph_b = 0;
    int ph_s = 0;

    always #5 clk = ~clk;

    ro_pair_counter u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_ro_a     (ro_a),
        .i_ro_b     (ro_b),
        .o_ro_en    (ro_en),
        .o_ro_rst   (ro_rst),
        .o_busy     (busy),
        .o_done     (done),
        .o_resp_bit (resp),
        .o_tie      (tie),
        .o_sat      (sat),
        .o_cnt_a    (cnt_a),
        .o_cnt_b    (cnt_b)
    );

    ro_pair_counter #(
        .CNT_W  (6),
        .WINDOW (S_WIN),
        .SETTLE (4)
    ) u_sat_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (s_start),
        .i_ro_a     (s_ro),
        .i_ro_b     (s_ro_b),
        .o_ro_en    (s_ro_en),
        .o_ro_rst   (s_ro_rst),
        .o_busy     (s_busy),
        .o_done     (s_done),
        .o_resp_bit (s_resp),
        .o_tie      (s_tie),
        .o_sat      (s_sat),
        .o_cnt_a    (s_cnt_a),
        .o_cnt_b    (s_cnt_b)
    );

    // RO models: run only while enabled, forced low while held.
    always @(negedge clk) begin
        if (noise) begin
            if (ro_rst) begin
                ro_a = ~ro_a;
                ro_b = ~ro_b;
            end else begin
                ro_a = 1'b0;
                ro_b = 1'b0;
            end
        end else if (ro_rst) begin
            ro_a = 1'b0; ro_b = 1'b0; ph_a = 0; ph_b = 0;
        end else if (ro_en) begin
            if (half_a != 0) begin
                ph_a++;
                if (ph_a == half_a) begin ro_a = ~ro_a; ph_a = 0; end
            end
            if (half_b != 0) begin
                ph_b++;
                if (ph_b == half_b) begin ro_b = ~ro_b; ph_b = 0; end
            end
        end
        if (s_ro_rst) begin
            s_ro = 1'b0; ph_s = 0;
        end else if (s_ro_en && s_half != 0) begin
            ph_s++;
            if (ph_s == s_half) begin s_ro = ~s_ro; ph_s = 0; end
        end
    end

    always @(negedge clk) if (done === 1'b1) n_done++;

    function automatic exp_t mk_exp(bit r, bit t, bit s, int alo, int ahi, int blo, int bhi);
        exp_t e;
        e.resp = r; e.tie = t; e.sat = s;
        e.a_lo = alo; e.a_hi = ahi; e.b_lo = blo; e.b_hi = bhi;
        return e;
    endfunction

    // Returns 1 ns after the accept edge.
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // lat = number of edges after the accept edge until Done is seen, -1 on timeout.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({ro_rst, ro_en, busy, done, resp, tie, sat} !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rst/en/busy/done/resp/tie/sat=%b want 1000000",
                     {ro_rst, ro_en, busy, done, resp, tie, sat});
        end
        n_checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got a=%0d b=%0d want 0 0", cnt_a, cnt_b);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_measure(input string tag, input int ha, input int hb);
        int   lat;
        exp_t e;
        half_a = ha; half_b = hb; noise = 0;
        if (ha == 4 && hb == 5)      exp_q.push_back(mk_exp(1, 0, 0, 127, 129, 101, 103));
        else if (ha == 5 && hb == 4) exp_q.push_back(mk_exp(0, 0, 0, 101, 103, 127, 129));
        else                         exp_q.push_back(mk_exp(0, 1, 0, 127, 129, 127, 129));
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || ro_rst !== 1'b1 || ro_en !== 1'b0) begin
            n_errors++;
            $display("FAIL %s settle: got busy=%b rst=%b en=%b want 1 1 0", tag, busy, ro_rst, ro_en);
        end
        wait_done(LAT + 20, lat);
        n_checks++;
        if (lat !== LAT) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (resp !== e.resp || tie !== e.tie || sat !== e.sat) begin
            n_errors++;
            $display("FAIL %s flags: got resp=%b tie=%b sat=%b want %b %b %b",
                     tag, resp, tie, sat, e.resp, e.tie, e.sat);
        end
        n_checks++;
        if (int'(cnt_a) < e.a_lo || int'(cnt_a) > e.a_hi || int'(cnt_b) < e.b_lo
            || int'(cnt_b) > e.b_hi) begin
            n_errors++;
            $display("FAIL %s counts: got a=%0d b=%0d want a in %0d..%0d b in %0d..%0d",
                     tag, cnt_a, cnt_b, e.a_lo, e.a_hi, e.b_lo, e.b_hi);
        end
        if (e.tie) begin
            n_checks++;
            if (cnt_a !== cnt_b) begin
                n_errors++;
                $display("FAIL %s equal: got a=%0d b=%0d want equal", tag, cnt_a, cnt_b);
            end
        end
        // Results must hold in IDLE.
        repeat (5) @(negedge clk);
        n_checks++;
        if (resp !== e.resp || tie !== e.tie || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s hold: got resp=%b tie=%b busy=%b want %b %b 0",
                     tag, resp, tie, busy, e.resp, e.tie);
        end
    endtask

    task automatic test_saturation();
        int lat;
        s_half = 2;
        @(negedge clk); s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= S_LAT + 20; c++) begin
            @(posedge clk); #1;
            if (s_done === 1'b1) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== S_LAT) begin
            n_errors++;
            $display("FAIL sat latency: got %0d want %0d", lat, S_LAT);
        end
        n_checks++;
        if (s_cnt_a !== 6'd63 || s_sat !== 1'b1 || s_resp !== 1'b1) begin
            n_errors++;
            $display("FAIL sat result: got a=%0d sat=%b resp=%b want 63 1 1", s_cnt_a, s_sat, s_resp);
        end
        s_half = 0;
        @(negedge clk); s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        n_checks++;
        if (s_sat !== 1'b0 || s_cnt_a !== 6'd0) begin
            n_errors++;
            $display("FAIL sat clear: got sat=%b a=%0d want 0 0", s_sat, s_cnt_a);
        end
        lat = -1;
        for (int c = 1; c <= S_LAT + 20; c++) begin
            @(posedge clk); #1;
            if (s_done === 1'b1) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== S_LAT || s_sat !== 1'b0 || s_tie !== 1'b1) begin
            n_errors++;
            $display("FAIL sat rerun: got lat=%0d sat=%b tie=%b want %0d 0 1", lat, s_sat, s_tie, S_LAT);
        end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        half_a = 4; half_b = 5; noise = 0;
        pulse_start();
        repeat (500) @(posedge clk);
        d0 = n_done;
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ro_rst, ro_en, busy, done, resp, tie, sat} !== 7'b1000000
            || cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: got ctrl=%b a=%0d b=%0d want 1000000 0 0",
                     {ro_rst, ro_en, busy, done, resp, tie, sat}, cnt_a, cnt_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (600) @(negedge clk);
        n_checks++;
        if (n_done !== d0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_nodone: got dones=%0d busy=%b want %0d 0", n_done, busy, d0);
        end
        test_measure("after_reset", 4, 5);
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   drops;
        int   d0;
        exp_t e;
        half_a = 5; half_b = 4; noise = 0;
        exp_q.push_back(mk_exp(0, 0, 0, 101, 103, 127, 129));
        d0 = n_done;
        drops = 0;
        lat = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = c; break; end
            if (busy !== 1'b1) drops++;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (lat !== LAT || drops !== 0) begin
            n_errors++;
            $display("FAIL b2b timing: got lat=%0d busy_drops=%0d want %0d 0", lat, drops, LAT);
        end
        n_checks++;
        if (n_done - d0 !== 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b dones: got %0d busy=%b want 1 0", n_done - d0, busy);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (resp !== e.resp || tie !== e.tie || int'(cnt_a) < e.a_lo || int'(cnt_a) > e.a_hi
            || int'(cnt_b) < e.b_lo || int'(cnt_b) > e.b_hi) begin
            n_errors++;
            $display("FAIL b2b result: got resp=%b tie=%b a=%0d b=%0d want %b %b", resp, tie,
                     cnt_a, cnt_b, e.resp, e.tie);
        end
    endtask

    task automatic test_idle_noise();
        int   lat;
        exp_t e;
        half_a = 0; half_b = 0; noise = 1;
        exp_q.push_back(mk_exp(0, 1, 0, 0, 0, 0, 0));
        repeat (7) @(negedge clk);
        pulse_start();
        wait_done(LAT + 20, lat);
        noise = 0;
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== LAT || resp !== e.resp || tie !== e.tie || int'(cnt_a) !== e.a_hi
            || int'(cnt_b) !== e.b_hi) begin
            n_errors++;
            $display("FAIL noise: got lat=%0d resp=%b tie=%b a=%0d b=%0d want %0d 0 1 0 0",
                     lat, resp, tie, cnt_a, cnt_b, LAT);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_measure("a_faster", 4, 5);
        test_measure("b_faster", 5, 4);
        test_measure("tie", 4, 4);
        test_saturation();
        test_reset_mid_run();
        test_back_to_back();
        test_idle_noise();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
